// File: rtl/gpu_sram_pkg.sv
// gpu_sram_pkg: shared state encoding, default geometry and packed-pixel field offsets for the GPU/SRAM port
package gpu_sram_pkg;
    localparam int ADDR_W_DEF   = 18;
    localparam int DATA_W_DEF   = 16;
    localparam int FB_WORDS_DEF = 640 * 400;
    localparam int PIX_FIELD_W  = 4;
    localparam int PIX_R_LSB    = 12;
    localparam int PIX_G_LSB    = 8;
    localparam int PIX_B_LSB    = 4;
    localparam int PIX_PAD_LSB  = 0;
    typedef enum logic [2:0] {IDLE, WR, WR_REC, RD, RD_DONE, VERIFY} state_t;
endpackage

// File: rtl/sram_sweep_counter.sv
// sram_sweep_counter: wrapping address counter with enable and synchronous clear
module sram_sweep_counter #(
    parameter int W    = 18,
    parameter int WRAP = 256000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (en) count <= (count == W'(WRAP - 1)) ? '0 : count + W'(1);
endmodule

// File: rtl/sram_gpu_responder.sv
// sram_gpu_responder: GPU blanking-time SRAM access engine plus sweep address source; SRAM_WR_VERIFY_EN adds write readback and O_WR_ERR
module sram_gpu_responder
    import gpu_sram_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FB_WORDS = FB_WORDS_DEF,
    parameter int READ_LAT = 2
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_VIDEO_ON,
    input  logic [DATA_W-1:0] I_GPU_DATA,
    input  logic [ADDR_W-1:0] I_GPU_ADDR,
    input  logic              I_GPU_WRITE,
    input  logic              I_GPU_READ,
    output logic [ADDR_W-1:0] O_GPU_ADDR,
    output logic [DATA_W-1:0] O_GPU_RDATA,
    output logic              O_GPU_RVALID,
    output logic              O_GPU_BUSY,
    output logic [ADDR_W-1:0] O_SRAM_ADDR,
    output logic [DATA_W-1:0] O_SRAM_DQ_OUT,
    output logic              O_SRAM_DQ_OE,
    input  logic [DATA_W-1:0] I_SRAM_DQ_IN,
    output logic              O_SRAM_CE_N,
    output logic              O_SRAM_WE_N,
    output logic              O_SRAM_OE_N,
    output logic              O_SRAM_UB_N,
    output logic              O_SRAM_LB_N
`ifdef SRAM_WR_VERIFY_EN
    ,
    output logic              O_WR_ERR
`endif
);
`ifdef SRAM_WR_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    state_t state, state_n;
    logic [2:0] cnt;
    logic vfy;
    logic acc_wr, acc_rd;
    assign acc_wr = state == IDLE && !I_VIDEO_ON && I_GPU_WRITE;
    assign acc_rd = state == IDLE && !I_VIDEO_ON && !I_GPU_WRITE && I_GPU_READ;
    assign O_SRAM_UB_N = 1'b0;
    assign O_SRAM_LB_N = 1'b0;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = acc_wr ? WR : acc_rd ? RD : IDLE;
            WR:      state_n = WR_REC;
            WR_REC:  state_n = VFY ? RD : IDLE;
            RD:      state_n = cnt != 3'd0 ? RD : vfy ? VERIFY : RD_DONE;
            default: state_n = IDLE;
        endcase
    end
    // Strobes are registered from the next state so they line up with the state they belong to
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state         <= IDLE;
            cnt           <= 3'(READ_LAT - 1);
            vfy           <= 1'b0;
            O_GPU_RDATA   <= '0;
            O_GPU_RVALID  <= 1'b0;
            O_GPU_BUSY    <= 1'b0;
            O_SRAM_ADDR   <= '0;
            O_SRAM_DQ_OUT <= '0;
            O_SRAM_DQ_OE  <= 1'b0;
            O_SRAM_CE_N   <= 1'b1;
            O_SRAM_WE_N   <= 1'b1;
            O_SRAM_OE_N   <= 1'b1;
`ifdef SRAM_WR_VERIFY_EN
            O_WR_ERR      <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= (state == RD) ? cnt - 3'd1 : 3'(READ_LAT - 1);
            vfy   <= (state == WR_REC) ? 1'b1 : (state == IDLE) ? 1'b0 : vfy;
            if (acc_wr || acc_rd) begin
                O_SRAM_ADDR   <= I_GPU_ADDR;
                O_SRAM_DQ_OUT <= I_GPU_DATA;
            end
            if (state == RD && state_n == RD_DONE) O_GPU_RDATA <= I_SRAM_DQ_IN;
            O_GPU_RVALID <= state == RD && state_n == RD_DONE;
            O_GPU_BUSY   <= state_n != IDLE;
            O_SRAM_DQ_OE <= state_n inside {WR, WR_REC};
            O_SRAM_CE_N  <= !(state_n inside {WR, WR_REC, RD});
            O_SRAM_WE_N  <= state_n != WR;
            O_SRAM_OE_N  <= state_n != RD;
`ifdef SRAM_WR_VERIFY_EN
            O_WR_ERR <= O_WR_ERR || (state == RD && state_n == VERIFY && I_SRAM_DQ_IN != O_SRAM_DQ_OUT);
`endif
        end
    end
    sram_sweep_counter #(
        .W    (ADDR_W),
        .WRAP (FB_WORDS)
    ) u_sweep (
        .clk   (I_CLK),
        .rst   (I_RST),
        .clr   (1'b0),
        .en    (acc_wr),
        .count (O_GPU_ADDR)
    );
endmodule

// File: tb/tb_sram_gpu_responder.sv
// tb_sram_gpu_responder: directed and randomized checks of sram_gpu_responder against a word-level SRAM model
module tb_sram_gpu_responder;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int FB = 20;
    localparam int RL = 2;
`ifdef SRAM_WR_VERIFY_EN
    localparam int WPER = 3 + RL + 1;
`else
    localparam int WPER = 3;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic video_on = 1'b0;
    logic [DW-1:0] gpu_data = '0;
    logic [AW-1:0] gpu_addr = '0;
    logic gpu_write = 1'b0;
    logic gpu_read = 1'b0;
    logic [AW-1:0] sweep;
    logic [DW-1:0] rdata;
    logic rvalid, busy;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] dq_out, dq_in;
    logic dq_oe, ce_n, we_n, oe_n, ub_n, lb_n;
    logic corrupt = 1'b0;
    logic wr_err;
    logic [DW-1:0] mem [256];
    int wr_cnt = 0;
    int rv_cnt = 0;
    bit overlap = 1'b0;
    int total = 0;
    int passed = 0;
    int sweep_exp = 0;
    logic [DW-1:0] exp_mem [int];
    int wq [$];
    always #5 clk = ~clk;
    sram_gpu_responder #(
        .ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FB), .READ_LAT(RL)
    ) dut (
        .I_CLK(clk), .I_RST(rst), .I_VIDEO_ON(video_on),
        .I_GPU_DATA(gpu_data), .I_GPU_ADDR(gpu_addr),
        .I_GPU_WRITE(gpu_write), .I_GPU_READ(gpu_read),
        .O_GPU_ADDR(sweep), .O_GPU_RDATA(rdata), .O_GPU_RVALID(rvalid), .O_GPU_BUSY(busy),
        .O_SRAM_ADDR(sram_addr), .O_SRAM_DQ_OUT(dq_out), .O_SRAM_DQ_OE(dq_oe),
        .I_SRAM_DQ_IN(dq_in),
        .O_SRAM_CE_N(ce_n), .O_SRAM_WE_N(we_n), .O_SRAM_OE_N(oe_n),
        .O_SRAM_UB_N(ub_n), .O_SRAM_LB_N(lb_n)
`ifdef SRAM_WR_VERIFY_EN
        , .O_WR_ERR(wr_err)
`endif
    );
`ifndef SRAM_WR_VERIFY_EN
    assign wr_err = 1'b0;
`endif
    // External SRAM: writes on WE_N low, drives DQ while output-enabled, optional bit-0 fault on reads
    assign dq_in = (!ce_n && !oe_n) ? (mem[sram_addr[7:0]] ^ {15'b0, corrupt}) : '0;
    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[7:0]] <= dq_out;
        if (!ce_n && !we_n) wr_cnt <= wr_cnt + 1;
        if (rvalid) rv_cnt <= rv_cnt + 1;
        if (dq_oe && !oe_n) overlap <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        gpu_addr = AW'(a);
        gpu_data = d;
        gpu_write = 1'b1;
        @(negedge clk);
        gpu_write = 1'b0;
        wait_idle("wr");
        sweep_exp = (sweep_exp + 1) % FB;
        if (!exp_mem.exists(a)) wq.push_back(a);
        exp_mem[a] = d;
        chk("wr_sweep", sweep, sweep_exp);
    endtask

    task automatic do_read(input int a);
        int n = 0;
        gpu_addr = AW'(a);
        gpu_read = 1'b1;
        @(negedge clk);
        gpu_read = 1'b0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_rvalid", rvalid, 1);
        chk("rd_data", rdata, exp_mem[a]);
        @(negedge clk);
        wait_idle("rd");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, r0, nexp;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ce_n", ce_n, 1);
        chk("rst_we_n", we_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_ublb", {ub_n, lb_n}, 0);
        chk("rst_dq_oe", dq_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sweep", sweep, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_dq_out", dq_out, 0);
        // Single write with per-cycle strobe checks
        gpu_addr = 18'h00010;
        gpu_data = 16'h0F00;
        gpu_write = 1'b1;
        @(negedge clk);
        gpu_write = 1'b0;
        chk("w1_we_n", we_n, 0);
        chk("w1_ce_n", ce_n, 0);
        chk("w1_addr", sram_addr, 18'h00010);
        chk("w1_dq", dq_out, 16'h0F00);
        chk("w1_dq_oe", dq_oe, 1);
        chk("w1_oe_n", oe_n, 1);
        @(negedge clk);
        chk("w2_we_n", we_n, 1);
        chk("w2_dq_oe", dq_oe, 1);
        chk("w2_ce_n", ce_n, 0);
        @(negedge clk);
        chk("w3_dq_oe", dq_oe, 0);
`ifndef SRAM_WR_VERIFY_EN
        chk("w3_ce_n", ce_n, 1);
        chk("w3_busy", busy, 0);
`else
        chk("w3_readback_oe_n", oe_n, 0);
`endif
        wait_idle("w1");
        sweep_exp = 1;
        exp_mem[16] = 16'h0F00;
        wq.push_back(16);
        chk("w1_sweep", sweep, 1);
        // Reset held two cycles while the FSM is in WR
        r0 = rv_cnt;
        gpu_addr = 18'h000F0;
        gpu_data = 16'hDEAD;
        gpu_write = 1'b1;
        @(negedge clk);
        gpu_write = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sweep_exp = 0;
        chk("mid_rst_ce_we_oe", {ce_n, we_n, oe_n}, 3'b111);
        chk("mid_rst_dq_oe", dq_oe, 0);
        chk("mid_rst_sweep", sweep, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_rvalid", rv_cnt - r0, 0);
        // Read with cycle-exact RVALID timing
        do_write(32, 16'hABC0);
        gpu_addr = 18'h00020;
        gpu_read = 1'b1;
        @(negedge clk);
        gpu_read = 1'b0;
        chk("r1_oe_n", oe_n, 0);
        chk("r1_dq_oe", dq_oe, 0);
        chk("r1_rvalid", rvalid, 0);
        @(negedge clk);
        chk("r2_rvalid", rvalid, 0);
        chk("r2_dq_oe", dq_oe, 0);
        @(negedge clk);
        chk("r3_rvalid", rvalid, 1);
        chk("r3_rdata", rdata, 16'hABC0);
        chk("r3_oe_n", oe_n, 1);
        @(negedge clk);
        chk("r4_rvalid", rvalid, 0);
        chk("r4_rdata_hold", rdata, 16'hABC0);
        // Write beats read; held requests re-accepted every write period
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sweep_exp = 0;
        w0 = wr_cnt;
        r0 = rv_cnt;
        gpu_addr = 18'h00030;
        gpu_data = 16'h5A5A;
        gpu_write = 1'b1;
        gpu_read = 1'b1;
        repeat (9) @(negedge clk);
        gpu_write = 1'b0;
        gpu_read = 1'b0;
        wait_idle("prio");
        nexp = (9 + WPER - 1) / WPER;
        chk("prio_writes", wr_cnt - w0, nexp);
        chk("prio_no_read", rv_cnt - r0, 0);
        chk("prio_sweep", sweep, nexp);
        sweep_exp = nexp;
        exp_mem[48] = 16'h5A5A;
        wq.push_back(48);
        // VIDEO_ON rising during a read: read completes, then nothing is accepted
        w0 = wr_cnt;
        gpu_addr = 18'h00020;
        gpu_read = 1'b1;
        @(negedge clk);
        video_on = 1'b1;
        gpu_write = 1'b1;
        begin
            int n = 0;
            while (!rvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("blank_rvalid", rvalid, 1);
        chk("blank_rdata", rdata, 16'hABC0);
        r0 = rv_cnt + 1;
        repeat (10) @(negedge clk);
        chk("blank_busy", busy, 0);
        chk("blank_no_write", wr_cnt - w0, 0);
        chk("blank_no_read", rv_cnt - r0, 0);
        chk("blank_sweep", sweep, sweep_exp);
        gpu_write = 1'b0;
        gpu_read = 1'b0;
        video_on = 1'b0;
        @(negedge clk);
        // Randomized traffic against the word-level model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) do_write(int'($urandom_range(0, 63)), DW'($urandom));
            else do_read(wq[$urandom_range(0, wq.size() - 1)]);
        end
        while (sweep_exp != FB - 1) do_write(int'($urandom_range(0, 63)), DW'($urandom));
        do_write(7, 16'h0007);
        chk("wrap_sweep", sweep, 0);
        do_read(7);
        chk("no_oe_overlap", overlap, 0);
        chk("wr_err_clean", wr_err, 0);
`ifdef SRAM_WR_VERIFY_EN
        r0 = rv_cnt;
        corrupt = 1'b1;
        do_write(64, 16'h1230);
        corrupt = 1'b0;
        chk("vfy_err_set", wr_err, 1);
        chk("vfy_no_rvalid", rv_cnt - r0, 0);
        do_write(65, 16'h1111);
        chk("vfy_err_sticky", wr_err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("vfy_err_cleared", wr_err, 0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
